// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-style main control unit.
// Moore FSM with registered control outputs and a debug state port.
module controle_multiciclo (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    output logic [2:0] ALUop,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Branch,
    output logic       BranchNe,
    output logic [3:0] estado
);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_BNE      = 4'd9,
        S_IMMEXEC  = 4'd10,
        S_IMMWB    = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       iord;
        logic       alu_src_a;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       branch_ne;
    } ctrl_t;

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    ctrl_t  w_ctrl;

    // Control word for a state; only IMMEXEC looks at the opcode.
    function automatic ctrl_t f_ctrl(input state_t s, input logic [5:0] o);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_b = 2'b01;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                c.iord = 1'b1;
            end
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 3'b010;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 3'b001;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            S_BNE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 3'b100;
                c.pc_src    = 2'b01;
                c.branch_ne = 1'b1;
            end
            S_IMMEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                case (o)
                    OP_SLTI: c.alu_op = 3'b011;
                    OP_ANDI: c.alu_op = 3'b101;
                    OP_ORI:  c.alu_op = 3'b110;
                    OP_XORI: c.alu_op = 3'b111;
                    default: c.alu_op = 3'b000;
                endcase
            end
            S_IMMWB: begin
                c.reg_write = 1'b1;
            end
            S_JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection; unused codes fall back to FETCH.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYP:      w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_BNE:       w_next = S_BNE;
                    OP_ADDI, OP_SLTI, OP_ANDI,
                    OP_ORI, OP_XORI:
                                  w_next = S_IMMEXEC;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: w_next = S_MEMWB;
            S_EXECUTE: w_next = S_ALUWB;
            S_IMMEXEC: w_next = S_IMMWB;
            default:   w_next = S_FETCH;
        endcase
        w_ctrl = f_ctrl(w_next, op);
    end

    // State register plus control word registered for the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= S_FETCH;
            r_ctrl           <= '0;
            r_ctrl.alu_src_b <= 2'b01;
            r_ctrl.ir_write  <= 1'b1;
            r_ctrl.pc_write  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_ctrl  <= w_ctrl;
        end
    end

    assign ALUop    = r_ctrl.alu_op;
    assign IorD     = r_ctrl.iord;
    assign ALUSrcA  = r_ctrl.alu_src_a;
    assign RegDst   = r_ctrl.reg_dst;
    assign MemtoReg = r_ctrl.mem_to_reg;
    assign ALUSrcB  = r_ctrl.alu_src_b;
    assign PCSrc    = r_ctrl.pc_src;
    assign IRWrite  = r_ctrl.ir_write;
    assign PCWrite  = r_ctrl.pc_write;
    assign RegWrite = r_ctrl.reg_write;
    assign MemWrite = r_ctrl.mem_write;
    assign Branch   = r_ctrl.branch;
    assign BranchNe = r_ctrl.branch_ne;
    assign estado   = r_state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: directed and random instruction streams
// compared against a table model of per-instruction state walks.
module tb_controle_multiciclo;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [5:0] op = 6'd0;
    logic [2:0] ALUop;
    logic       IorD, ALUSrcA, RegDst, MemtoReg;
    logic [1:0] ALUSrcB, PCSrc;
    logic       IRWrite, PCWrite, RegWrite, MemWrite;
    logic       Branch, BranchNe;
    logic [3:0] estado;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] legal [11] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                               6'b000101, 6'b001000, 6'b001010, 6'b001100,
                               6'b001101, 6'b001110, 6'b000010};

    controle_multiciclo dut (
        .clk(clk), .reset_n(reset_n), .op(op),
        .ALUop(ALUop), .IorD(IorD), .ALUSrcA(ALUSrcA), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .Branch(Branch), .BranchNe(BranchNe),
        .estado(estado)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] pk(
        input logic [2:0] alu, input logic iord, input logic sa,
        input logic rd, input logic m2r, input logic [1:0] sb,
        input logic [1:0] pcs, input logic irw, input logic pcw,
        input logic rw, input logic mw, input logic br, input logic bn);
        return {alu, iord, sa, rd, m2r, sb, pcs, irw, pcw, rw, mw, br, bn};
    endfunction

    // Expected control word for a state code, straight from the state table.
    function automatic logic [16:0] exp_out(input int s, input logic [5:0] o);
        logic [2:0] ia;
        case (o)
            6'b001010: ia = 3'b011;
            6'b001100: ia = 3'b101;
            6'b001101: ia = 3'b110;
            6'b001110: ia = 3'b111;
            default:   ia = 3'b000;
        endcase
        case (s)
            0:  return pk(0, 0, 0, 0, 0, 2'b01, 0, 1, 1, 0, 0, 0, 0);
            1:  return pk(0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
            2:  return pk(0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
            3:  return pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            4:  return pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
            5:  return pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            6:  return pk(3'b010, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            7:  return pk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            8:  return pk(3'b001, 0, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1, 0);
            9:  return pk(3'b100, 0, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 1);
            10: return pk(ia, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
            11: return pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            12: return pk(0, 0, 0, 0, 0, 0, 2'b10, 0, 1, 0, 0, 0, 0);
            default: return '0;
        endcase
    endfunction

    // State walk of one instruction, FETCH first, next FETCH excluded.
    task automatic get_seq(input logic [5:0] o, output int s[8], output int n);
        s = '{default: 0};
        s[1] = 1;
        n = 2;
        case (o)
            6'b100011: begin s[2] = 2; s[3] = 3; s[4] = 4; n = 5; end
            6'b101011: begin s[2] = 2; s[3] = 5; n = 4; end
            6'b000000: begin s[2] = 6; s[3] = 7; n = 4; end
            6'b000100: begin s[2] = 8; n = 3; end
            6'b000101: begin s[2] = 9; n = 3; end
            6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110:
                begin s[2] = 10; s[3] = 11; n = 4; end
            6'b000010: begin s[2] = 12; n = 3; end
            default: n = 2;
        endcase
    endtask

    function automatic logic [16:0] obs_out();
        return {ALUop, IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc,
                IRWrite, PCWrite, RegWrite, MemWrite, Branch, BranchNe};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_state(input string tag, input int s,
                             input logic [5:0] o);
        chk({tag, "_estado"}, 32'(estado), 32'(s));
        chk({tag, "_outs"}, 32'(obs_out()), 32'(exp_out(s, o)));
        chk({tag, "_onestrobe"},
            32'($countones({RegWrite, MemWrite, IRWrite}) <= 1), 32'd1);
    endtask

    // Called #1 after the edge that entered FETCH.
    task automatic run_instr(input logic [5:0] o, input string tag);
        int s[8];
        int n;
        get_seq(o, s, n);
        op = o;
        for (int i = 0; i < n; i++) begin
            chk_state(tag, s[i], o);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [5:0] rand_op();
        int k;
        logic [5:0] x;
        bit ok;
        k = $urandom_range(0, 11);
        if (k < 11) return legal[k];
        ok = 1'b0;
        x = 6'b111111;
        while (!ok) begin
            x = 6'($urandom);
            ok = 1'b1;
            for (int j = 0; j < 11; j++) if (legal[j] == x) ok = 1'b0;
        end
        return x;
    endfunction

    initial begin
        #1 reset_n = 1'b0;
        #1;
        chk_state("reset_async", 0, 6'd0);
        @(posedge clk);
        #1;
        chk_state("reset_held", 0, 6'd0);
        reset_n = 1'b1;

        run_instr(6'b100011, "lw");
        run_instr(6'b101011, "sw");
        run_instr(6'b000000, "rtype");
        run_instr(6'b000100, "beq");
        run_instr(6'b000101, "bne");
        run_instr(6'b001000, "addi");
        run_instr(6'b001010, "slti");
        run_instr(6'b001100, "andi");
        run_instr(6'b001101, "ori");
        run_instr(6'b001110, "xori");
        run_instr(6'b000010, "j");
        run_instr(6'b111111, "illegal");

        for (int r = 0; r < 60; r++)
            run_instr(rand_op(), "rand");

        op = 6'b100011;
        chk_state("midrst_s0", 0, op);
        @(posedge clk); #1;
        chk_state("midrst_s1", 1, op);
        @(posedge clk); #1;
        chk_state("midrst_s2", 2, op);
        @(posedge clk); #1;
        chk_state("midrst_s3", 3, op);
        #2 reset_n = 1'b0;
        #1;
        chk_state("midrst_async", 0, op);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk_state("midrst_hold", 0, op);
        end
        reset_n = 1'b1;
        run_instr(6'b000000, "after_rst");

        for (int r = 0; r < 10; r++)
            run_instr(rand_op(), "rand2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
